// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, reset/bubble constants, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W = 32;

  // PC value loaded on reset and the word placed into IF/ID for a bubble.
  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Fetch FSM: RUN = IF/ID holds a fetched instruction, STALL = IF/ID frozen,
  // REDIRECT = IF/ID holds a bubble after a branch/jump redirect.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // Which path the next PC was taken from this cycle.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_t;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selector: branch > jump > stall-hold > sequential, with target alignment.
// Latency: purely combinational, zero cycles.
// Backpressure: stall selects the hold path unless a redirect overrides it.
//
// Ports:
//   pc, pc4_hi        current PC and upper nibble of IF/ID PC+4 (jump region)
//   branch_target     EX-computed branch destination (may be misaligned)
//   jump_index        instr[25:0] of the jump sitting in ID
//   pc_src, jump, if_id_valid, stall   redirect / hold requests
//   pc_next, pc_plus4 selected next PC and the sequential PC
//   sel               which path was selected
//   misaligned        a taken branch carried a non-word-aligned target
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [3:0]        pc4_hi,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [25:0]       jump_index,
  input  logic              pc_src,
  input  logic              jump,
  input  logic              if_id_valid,
  input  logic              stall,
  output logic [WORD_W-1:0] pc_next,
  output logic [WORD_W-1:0] pc_plus4,
  output pc_sel_t           sel,
  output logic              misaligned
);

  always_comb begin
    // Wraps modulo 2^32 with no flag.
    pc_plus4   = pc + 32'd4;
    misaligned = pc_src && (branch_target[1:0] != 2'b00);
    sel        = SEL_SEQ;
    pc_next    = pc_plus4;

    if (pc_src) begin
      sel     = SEL_BRANCH;
      pc_next = align_word(branch_target);
    end else if (jump && if_id_valid) begin
      // A jump decoded from a bubble is not a real jump, so it needs a valid IF/ID.
      sel     = SEL_JUMP;
      pc_next = {pc4_hi, jump_index, 2'b00};
    end else if (stall) begin
      sel     = SEL_HOLD;
      pc_next = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Latency: instruction at pc appears on if_id_* one cycle later; redirect costs one bubble.
// Backpressure: stall freezes pc and IF/ID; pc_src/jump redirects override stall.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   pc_src, branch_target     taken-branch redirect from EX
//   jump, jump_index          J-type redirect from ID
//   stall                     hazard-unit hold request
//   instr_in                  combinational instruction memory data at pc
//   pc                        instruction memory address (the PC register)
//   if_id_instr/pc4/valid     IF/ID pipeline register
//   flush                     one-cycle pulse after a redirect edge
//   fetch_count               valid instructions loaded into IF/ID (wraps)
//   addr_error                sticky: a misaligned redirect target was seen
module pc_fetch_stage
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_src,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              stall,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              flush,
  output logic [WORD_W-1:0] fetch_count,
  output logic              addr_error
);

  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] pc_plus4;
  pc_sel_t           sel;
  logic              misaligned;
  fetch_state_t      state_q;
  fetch_state_t      state_d;

  pc_next_mux u_pc_next_mux (
    .pc            (pc),
    .pc4_hi        (if_id_pc4[31:28]),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .pc_src        (pc_src),
    .jump          (jump),
    .if_id_valid   (if_id_valid),
    .stall         (stall),
    .pc_next       (pc_next),
    .pc_plus4      (pc_plus4),
    .sel           (sel),
    .misaligned    (misaligned)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the selected path; no state ever blocks a redirect.
  always_comb begin
    state_d = RUN;
    case (sel)
      SEL_BRANCH, SEL_JUMP: state_d = REDIRECT;
      SEL_HOLD:             state_d = STALL;
      default:              state_d = RUN;
    endcase
  end

  // REDIRECT lasts exactly the bubble cycle, so flush is a straight decode of
  // the state flop and drops on the next edge even if stall is asserted.
  assign flush = (state_q == REDIRECT);

  // PC and IF/ID datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
      addr_error  <= 1'b0;
    end else begin
      pc <= pc_next;
      case (sel)
        SEL_SEQ: begin
          if_id_instr <= instr_in;
          if_id_pc4   <= pc_plus4;
          if_id_valid <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end
        SEL_BRANCH, SEL_JUMP: begin
          if_id_instr <= NOP_INSTR;
          if_id_pc4   <= '0;
          if_id_valid <= 1'b0;
        end
        default: begin
          // Hold: IF/ID frozen.
        end
      endcase
      if (misaligned) begin
        addr_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        stall = 1'b0;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        flush;
  logic [31:0] fetch_count;
  logic        addr_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural view of the fetch stage).
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_flush, m_err;

  localparam logic [130:0] RESET_VEC = {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};

  always #5 clock = ~clock;

  // Instruction memory: a fixed pseudo-random word per address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign instr_in = mem_f(pc);

  pc_fetch_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .stall         (stall),
    .instr_in      (instr_in),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .flush         (flush),
    .fetch_count   (fetch_count),
    .addr_error    (addr_error)
  );

  // pc4 is only meaningful for a valid IF/ID entry.
  function automatic logic [130:0] dut_vec();
    return {pc, if_id_valid, if_id_instr, (if_id_valid ? if_id_pc4 : 32'h0),
            flush, fetch_count, addr_error};
  endfunction

  function automatic logic [130:0] mdl_vec();
    return {m_pc, m_valid, m_instr, (m_valid ? m_pc4 : 32'h0), m_flush, m_cnt, m_err};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_flush = 1'b0; m_err = 1'b0;
  endtask

  // One clock of the architectural rules: branch > jump (if IF/ID valid) > stall > sequential.
  task automatic model_step(input logic ps, input logic [31:0] bt, input logic j,
                            input logic [25:0] ji, input logic st);
    logic [31:0] fetched;
    fetched = mem_f(m_pc);
    if (ps) begin
      if (bt % 4 != 0) m_err = 1'b1;
      m_pc = bt - (bt % 4);
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flush = 1'b1;
    end else if (j && m_valid) begin
      m_pc = (m_pc4 & 32'hF000_0000) + ({6'b0, ji} * 4);
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flush = 1'b1;
    end else if (st) begin
      m_flush = 1'b0;
    end else begin
      m_instr = fetched;
      m_pc4   = m_pc + 4;
      m_pc    = m_pc + 4;
      m_valid = 1'b1;
      m_flush = 1'b0;
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic cycle(input logic ps, input logic [31:0] bt, input logic j,
                       input logic [25:0] ji, input logic st);
    pc_src = ps; branch_target = bt; jump = j; jump_index = ji; stall = st;
    model_step(ps, bt, j, ji, st);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    pc_src = 1'b0; jump = 1'b0; stall = 1'b0; branch_target = '0; jump_index = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL seq_step%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if ({pc, if_id_pc4, fetch_count, if_id_instr} !== {32'd12, 32'd12, 32'd3, mem_f(32'd8)}) begin
      n_fail++;
      $display("FAIL seq_three: pc=%h pc4=%h cnt=%0d instr=%h expected pc=c pc4=c cnt=3 instr=%h",
               pc, if_id_pc4, fetch_count, if_id_instr, mem_f(32'd8));
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
      n_checks++;
      if ({pc, if_id_pc4, fetch_count, if_id_valid, flush} !== {32'd8, 32'd8, 32'd2, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: pc=%h pc4=%h cnt=%0d v=%b fl=%b expected pc=8 pc4=8 cnt=2 v=1 fl=0",
                 i, pc, if_id_pc4, fetch_count, if_id_valid, flush);
      end
    end
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    n_checks++;
    if ({pc, if_id_instr, fetch_count} !== {32'd12, mem_f(32'd8), 32'd3}) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h instr=%h cnt=%0d expected pc=c instr=%h cnt=3",
               pc, if_id_instr, fetch_count, mem_f(32'd8));
    end
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 26'h0, 1'b1);
    n_checks++;
    if ({pc, if_id_valid, flush, if_id_instr} !== {32'h40, 1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL branch_redirect: pc=%h v=%b fl=%b instr=%h expected pc=40 v=0 fl=1 instr=0",
               pc, if_id_valid, flush, if_id_instr);
    end
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    n_checks++;
    if ({pc, if_id_valid, flush, if_id_instr, if_id_pc4} !== {32'h44, 1'b1, 1'b0, mem_f(32'h40), 32'h44}) begin
      n_fail++;
      $display("FAIL branch_target_fetch: pc=%h v=%b fl=%b instr=%h pc4=%h expected pc=44 v=1 fl=0 instr=%h pc4=44",
               pc, if_id_valid, flush, if_id_instr, if_id_pc4, mem_f(32'h40));
    end
    // Flush must drop after one cycle even when the following cycle stalls.
    cycle(1'b1, 32'h80, 1'b0, 26'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL flush_under_stall: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_jump();
    do_reset();
    cycle(1'b1, 32'h1000_0004, 1'b0, 26'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 26'h10, 1'b0);
    n_checks++;
    if ({pc, if_id_valid, flush} !== {32'h1000_0040, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL jump_target: pc=%h v=%b fl=%b expected pc=10000040 v=0 fl=1",
               pc, if_id_valid, flush);
    end
    // Jump seen while IF/ID holds a bubble is ignored.
    cycle(1'b0, 32'h0, 1'b1, 26'h3FF, 1'b0);
    n_checks++;
    if ({pc, if_id_valid, flush} !== {32'h1000_0044, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_on_bubble: pc=%h v=%b fl=%b expected pc=10000044 v=1 fl=0",
               pc, if_id_valid, flush);
    end
    cycle(1'b1, 32'h200, 1'b1, 26'h10, 1'b0);
    n_checks++;
    if ({pc, flush} !== {32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL branch_beats_jump: pc=%h fl=%b expected pc=200 fl=1", pc, flush);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    cycle(1'b1, 32'h43, 1'b0, 26'h0, 1'b0);
    n_checks++;
    if ({pc, addr_error} !== {32'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL misaligned_target: pc=%h err=%b expected pc=40 err=1", pc, addr_error);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, $urandom, ($urandom_range(0, 2) == 0), 26'($urandom), ($urandom_range(0, 2) == 0));
    end
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL error_sticky: got %h expected %h", dut_vec(), mdl_vec());
    end
    do_reset();
    n_checks++;
    if (addr_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_cleared: err=%b expected 0", addr_error);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    n_checks++;
    if ({pc, if_id_pc4, if_id_instr, addr_error} !== {32'h0, 32'h0, mem_f(32'hFFFF_FFFC), 1'b0}) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h pc4=%h instr=%h err=%b expected pc=0 pc4=0 instr=%h err=0",
               pc, if_id_pc4, if_id_instr, addr_error, mem_f(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), RESET_VEC);
    end
    stall = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    n_checks++;
    if ({pc, if_id_instr, if_id_pc4, fetch_count} !== {32'h4, mem_f(32'h0), 32'h4, 32'h1}) begin
      n_fail++;
      $display("FAIL first_fetch_after_reset: pc=%h instr=%h pc4=%h cnt=%0d expected pc=4 instr=%h pc4=4 cnt=1",
               pc, if_id_instr, if_id_pc4, fetch_count, mem_f(32'h0));
    end
  endtask

  task automatic test_random();
    logic        ps, j, st;
    logic [31:0] bt;
    logic [25:0] ji;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ps = ($urandom_range(0, 7) == 0);
      bt = $urandom;
      if ($urandom_range(0, 5) != 0) bt[1:0] = 2'b00;
      j  = ($urandom_range(0, 5) == 0);
      ji = 26'($urandom);
      st = ($urandom_range(0, 3) == 0);
      cycle(ps, bt, j, ji, st);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_jump();
    test_misaligned();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
